// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: bus widths and one-hot FSM encodings.
package wb_arb_pkg;

  localparam int WB_ADR_W = 36;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [2:0] ARB_IDLE = 3'b001;
  localparam logic [2:0] ARB_OWN0 = 3'b010;
  localparam logic [2:0] ARB_OWN1 = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = ARB_IDLE,
    S_OWN0 = ARB_OWN0,
    S_OWN1 = ARB_OWN1
  } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-hang watchdog: counts strobe cycles without ack and flags expiry on the last allowed cycle.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TC_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TC  = TC_INT[CW-1:0];
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // The cycle that would reach TIMEOUT_CYCLES is the expiry cycle itself, so err fires on the Nth strobe.
  assign expire = (TIMEOUT_CYCLES > 0) && en && (cnt_q == TC);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter (m0 = LIMB/EC bridge, m1 = CPU side) with bus-hang watchdog.
//   state  | meaning
//   S_IDLE | no owner, slave outputs zero, arbitration of pending requests
//   S_OWN0 | master 0 owns the bus until it drops cyc or the watchdog fires
//   S_OWN1 | master 1 owns the bus until it drops cyc or the watchdog fires
import wb_arb_pkg::*;

module wb_arbiter_2m #(
  parameter bit FIXED_PRIO     = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic                m0_we_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic                m1_we_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [WB_DAT_W-1:0] m_dat_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic                s_we_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // 0: m0 owned last, 1: m1 owned last
  logic       own0, own1;
  logic       expire;
  logic       timeout_q;

  assign own0 = (state_q == S_OWN0);
  assign own1 = (state_q == S_OWN1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= expire;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (FIXED_PRIO || last_q) state_d = S_OWN0;
          else                      state_d = S_OWN1;
        end else if (m0_cyc_i) begin
          state_d = S_OWN0;
        end else if (m1_cyc_i) begin
          state_d = S_OWN1;
        end
      end
      S_OWN0: begin
        if (!m0_cyc_i || expire) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end
      end
      S_OWN1: begin
        if (!m1_cyc_i || expire) begin
          state_d = S_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_stb_o = m0_stb_i & m0_cyc_i;
      s_cyc_o = m0_cyc_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_stb_o = m1_stb_i & m1_cyc_i;
      s_cyc_o = m1_cyc_i;
    end
  end

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .nreset (nreset),
    .clr    (~s_stb_o | s_ack_i | (state_q == S_IDLE)),
    .en     (s_stb_o & ~s_ack_i),
    .expire (expire)
  );

  // Ack also needs the owner's cyc so a slave ack arriving as the master releases is dropped.
  assign m0_ack_o  = s_ack_i & own0 & m0_cyc_i;
  assign m1_ack_o  = s_ack_i & own1 & m1_cyc_i;
  assign m0_err_o  = expire & own0;
  assign m1_err_o  = expire & own1;
  assign m_dat_o   = s_dat_i;
  assign grant_o   = {own1, own0};
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: round-robin instance (a) and fixed-priority instance (b), both with an 8-cycle watchdog.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        nreset;
  logic [35:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;

  logic        m0_ack_a, m0_err_a, m1_ack_a, m1_err_a, s_we_a, s_stb_a, s_cyc_a, timeout_a;
  logic [31:0] m_dat_a, s_dat_a;
  logic [35:0] s_adr_a;
  logic [3:0]  s_sel_a;
  logic [1:0]  grant_a;

  logic        m0_ack_b, m0_err_b, m1_ack_b, m1_err_b, s_we_b, s_stb_b, s_cyc_b, timeout_b;
  logic [31:0] m_dat_b, s_dat_b;
  logic [35:0] s_adr_b;
  logic [3:0]  s_sel_b;
  logic [1:0]  grant_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .nreset(nreset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack_a), .m0_err_o(m0_err_a),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack_a), .m1_err_o(m1_err_a),
    .m_dat_o(m_dat_a), .s_adr_o(s_adr_a), .s_dat_o(s_dat_a), .s_sel_o(s_sel_a),
    .s_we_o(s_we_a), .s_stb_o(s_stb_a), .s_cyc_o(s_cyc_a),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(grant_a), .timeout_o(timeout_a)
  );

  wb_arbiter_2m #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .nreset(nreset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack_b), .m0_err_o(m0_err_b),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack_b), .m1_err_o(m1_err_b),
    .m_dat_o(m_dat_b), .s_adr_o(s_adr_b), .s_dat_o(s_dat_b), .s_sel_o(s_sel_b),
    .s_we_o(s_we_b), .s_stb_o(s_stb_b), .s_cyc_o(s_cyc_b),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(grant_b), .timeout_o(timeout_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat  = '0; s_ack  = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    clear_inputs();
    tick();
    tick();
    nreset = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    do_reset();
    chk("rst_grant", grant_a, 2'b00);
    chk("rst_s_cyc", s_cyc_a, 1'b0);
    chk("rst_s_stb", s_stb_a, 1'b0);
    chk("rst_timeout", timeout_a, 1'b0);
    chk("rst_acks", {m0_ack_a, m0_err_a, m1_ack_a, m1_err_a}, 4'b0000);

    // Async reset in the middle of an m0 write, then first tie goes to m0.
    m0_adr = 36'h0_1000_0000; m0_dat = 32'h1111_2222; m0_sel = 4'hF;
    m0_we = 1'b1; m0_stb = 1'b1; m0_cyc = 1'b1;
    #1;
    chk("t1_idle_adr_zero", s_adr_a, 36'h0);
    tick();
    chk("t1_grant_m0", grant_a, 2'b01);
    chk("t1_s_adr", s_adr_a, 36'h0_1000_0000);
    chk("t1_s_cyc", s_cyc_a, 1'b1);
    s_ack = 1'b1;
    #2;
    nreset = 1'b0;
    #1;
    chk("t1_async_grant", grant_a, 2'b00);
    chk("t1_async_s_cyc", s_cyc_a, 1'b0);
    chk("t1_async_no_ack_err", {m0_ack_a, m0_err_a}, 2'b00);
    tick();
    clear_inputs();
    nreset = 1'b1;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    #1;
    tick();
    chk("t1_tie_m0", grant_a, 2'b01);
    chk("t1_tie_m0_fp", grant_b, 2'b01);

    // Round-robin alternation with a dead cycle between owners.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_grant", grant_a, (i % 2 == 0) ? 2'b01 : 2'b10);
      s_ack = 1'b1;
      s_dat = 32'hA000_0000 + 32'(i);
      #1;
      chk("t2_ack_owner", (i % 2 == 0) ? m0_ack_a : m1_ack_a, 1'b1);
      chk("t2_ack_other", (i % 2 == 0) ? m1_ack_a : m0_ack_a, 1'b0);
      tick();
      s_ack = 1'b0;
      if (i % 2 == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else            begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      #1;
      chk("t2_release_cyc", s_cyc_a, 1'b0);
      tick();
      chk("t2_dead_grant", grant_a, 2'b00);
      chk("t2_dead_cyc", s_cyc_a, 1'b0);
      if (i % 2 == 0) begin m0_cyc = 1'b1; m0_stb = 1'b1; end
      else            begin m1_cyc = 1'b1; m1_stb = 1'b1; end
    end

    // Fixed priority: m0 wins every arbitration while it requests.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_fp_grant_m0", grant_b, 2'b01);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      chk("t3_fp_dead", grant_b, 2'b00);
      if (i < 2) begin m0_cyc = 1'b1; m0_stb = 1'b1; end
    end
    tick();
    chk("t3_fp_grant_m1", grant_b, 2'b10);

    // Watchdog expiry on an unacknowledged m1 read.
    do_reset();
    m1_adr = 36'h0_0000_0080; m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("t4_grant_m1", grant_a, 2'b10);
    for (int k = 1; k < 8; k++) begin
      chk("t4_no_err_early", m1_err_a, 1'b0);
      tick();
    end
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("t4_err_8th", m1_err_a, 1'b1);
    chk("t4_err_m0_gated", m0_err_a, 1'b0);
    chk("t4_timeout_not_yet", timeout_a, 1'b0);
    tick();
    chk("t4_timeout_pulse", timeout_a, 1'b1);
    chk("t4_s_cyc_forced", s_cyc_a, 1'b0);
    chk("t4_grant_idle", grant_a, 2'b00);
    chk("t4_err_cleared", m1_err_a, 1'b0);
    tick();
    chk("t4_timeout_one_cycle", timeout_a, 1'b0);
    chk("t4_m0_wins", grant_a, 2'b01);

    // Ack on the expiry cycle wins over the watchdog.
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ack = 1'b1;
    s_dat = 32'h1234_5678;
    #1;
    chk("t5_ack", m1_ack_a, 1'b1);
    chk("t5_no_err", m1_err_a, 1'b0);
    chk("t5_rdata", m_dat_a, 32'h1234_5678);
    tick();
    s_ack = 1'b0;
    chk("t5_no_timeout", timeout_a, 1'b0);
    chk("t5_still_m1", grant_a, 2'b10);

    // m0 write passes through exactly; m1 never sees the ack.
    do_reset();
    m0_adr = 36'h0_0000_0040; m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF;
    m0_we = 1'b1; m0_stb = 1'b1; m0_cyc = 1'b1;
    tick();
    s_ack = 1'b1;
    s_dat = 32'hCAFE_F00D;
    #1;
    chk("t6_adr", s_adr_a, 36'h0_0000_0040);
    chk("t6_dat", s_dat_a, 32'hDEAD_BEEF);
    chk("t6_sel", s_sel_a, 4'hF);
    chk("t6_we_stb_cyc", {s_we_a, s_stb_a, s_cyc_a}, 3'b111);
    chk("t6_m0_ack", m0_ack_a, 1'b1);
    chk("t6_m1_ack", m1_ack_a, 1'b0);
    chk("t6_m_dat", m_dat_a, 32'hCAFE_F00D);
    tick();
    s_ack = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t6_m1_ack_after", m1_ack_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
